// File: rtl/bwd_prop_out.sv
// Backward pass for the output layer of a small Q-network (5 hidden, 4 outputs).
// Only the chosen action's output neuron carries error. Given e = Q(act) - target,
// the block produces that neuron's bias update, its column of weight updates and
// the error propagated back to the hidden layer through the ReLU derivative.
// All data is signed Q6.10.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     pulse; request a pass (accepted only when idle)
//   act                       chosen action 0..3 (output neuron act+1)
//   target                    TD target Q value
//   lr_shift                  learning rate as an arithmetic right shift
//   a2_1..a2_5                hidden activations
//   a3_1..a3_4                output activations
//   w3_11..w3_54              output weights, hidden i to output j
//   deltaw3_11..deltaw3_54    weight updates (only column act+1 nonzero)
//   deltab3_1..deltab3_4      bias updates (only act+1 nonzero)
//   err2_1..err2_5            back-propagated hidden error
//   busy                      pass in progress
//   done                      one-cycle completion pulse
//
// Timing: ERR takes one cycle. UPD issues one hidden index per cycle into a
// product register and writes it back one cycle later, so UPD lasts six cycles
// and every output is final on the edge that enters DONE.
module bwd_prop_out (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  act,
   input  logic [15:0] target,
   input  logic [3:0]  lr_shift,
   input  logic [15:0] a2_1,
   input  logic [15:0] a2_2,
   input  logic [15:0] a2_3,
   input  logic [15:0] a2_4,
   input  logic [15:0] a2_5,
   input  logic [15:0] a3_1,
   input  logic [15:0] a3_2,
   input  logic [15:0] a3_3,
   input  logic [15:0] a3_4,
   input  logic [15:0] w3_11,
   input  logic [15:0] w3_12,
   input  logic [15:0] w3_13,
   input  logic [15:0] w3_14,
   input  logic [15:0] w3_21,
   input  logic [15:0] w3_22,
   input  logic [15:0] w3_23,
   input  logic [15:0] w3_24,
   input  logic [15:0] w3_31,
   input  logic [15:0] w3_32,
   input  logic [15:0] w3_33,
   input  logic [15:0] w3_34,
   input  logic [15:0] w3_41,
   input  logic [15:0] w3_42,
   input  logic [15:0] w3_43,
   input  logic [15:0] w3_44,
   input  logic [15:0] w3_51,
   input  logic [15:0] w3_52,
   input  logic [15:0] w3_53,
   input  logic [15:0] w3_54,
   output logic [15:0] deltaw3_11,
   output logic [15:0] deltaw3_12,
   output logic [15:0] deltaw3_13,
   output logic [15:0] deltaw3_14,
   output logic [15:0] deltaw3_21,
   output logic [15:0] deltaw3_22,
   output logic [15:0] deltaw3_23,
   output logic [15:0] deltaw3_24,
   output logic [15:0] deltaw3_31,
   output logic [15:0] deltaw3_32,
   output logic [15:0] deltaw3_33,
   output logic [15:0] deltaw3_34,
   output logic [15:0] deltaw3_41,
   output logic [15:0] deltaw3_42,
   output logic [15:0] deltaw3_43,
   output logic [15:0] deltaw3_44,
   output logic [15:0] deltaw3_51,
   output logic [15:0] deltaw3_52,
   output logic [15:0] deltaw3_53,
   output logic [15:0] deltaw3_54,
   output logic [15:0] deltab3_1,
   output logic [15:0] deltab3_2,
   output logic [15:0] deltab3_3,
   output logic [15:0] deltab3_4,
   output logic [15:0] err2_1,
   output logic [15:0] err2_2,
   output logic [15:0] err2_3,
   output logic [15:0] err2_4,
   output logic [15:0] err2_5,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StErr, StUpd, StDone} state_e;

   state_e state_q, state_d;

   // Input arrays: hidden index 1..5, output index 0..3 (= act)
   logic signed [15:0] a2_in [1:5];
   logic signed [15:0] a3_in [0:3];
   logic signed [15:0] w3_in [1:5][0:3];

   // Operands captured at the accepting edge
   logic [1:0]         act_q;
   logic [3:0]         lr_q;
   logic signed [15:0] tgt_q;
   logic signed [15:0] a3_q;
   logic signed [15:0] a2_q [1:5];
   logic signed [15:0] wc_q [1:5];

   logic signed [15:0] e_q;
   logic [2:0]         idx_q;

   // Product pipeline stage between issue and write-back
   logic signed [31:0] pp_q;
   logic signed [31:0] pq_q;
   logic [2:0]         pidx_q;
   logic               pgate_q;
   logic               pvalid_q;

   // Output registers
   logic [15:0] dw_q  [1:5][0:3];
   logic [15:0] db_q  [0:3];
   logic [15:0] err_q [1:5];

   // Combinational datapath
   logic [16:0]        diff;
   logic [15:0]        e_calc;
   logic [15:0]        db_calc;
   logic [2:0]         sel;
   logic signed [31:0] iss_p;
   logic signed [31:0] iss_q;
   logic               iss_gate;
   logic signed [31:0] pp_sh;
   logic signed [31:0] pq_sh;
   logic [15:0]        dw_calc;
   logic [15:0]        err_calc;

   // Clamp a wide signed value into signed 16-bit range.
   function automatic logic [15:0] sat33(input logic signed [32:0] v);
      if (v > 33'sd32767) begin
         return 16'h7FFF;
      end else if (v < -33'sd32768) begin
         return 16'h8000;
      end else begin
         return v[15:0];
      end
   endfunction

   // Saturating negation: -0x8000 becomes 0x7FFF.
   function automatic logic [15:0] neg16(input logic [15:0] x);
      return sat33(-$signed({{17{x[15]}}, x}));
   endfunction

   function automatic logic [15:0] shr(input logic [15:0] x, input logic [3:0] s);
      return $signed(x) >>> s;
   endfunction

   assign a2_in[1] = a2_1;
   assign a2_in[2] = a2_2;
   assign a2_in[3] = a2_3;
   assign a2_in[4] = a2_4;
   assign a2_in[5] = a2_5;

   assign a3_in[0] = a3_1;
   assign a3_in[1] = a3_2;
   assign a3_in[2] = a3_3;
   assign a3_in[3] = a3_4;

   assign w3_in[1][0] = w3_11;
   assign w3_in[1][1] = w3_12;
   assign w3_in[1][2] = w3_13;
   assign w3_in[1][3] = w3_14;
   assign w3_in[2][0] = w3_21;
   assign w3_in[2][1] = w3_22;
   assign w3_in[2][2] = w3_23;
   assign w3_in[2][3] = w3_24;
   assign w3_in[3][0] = w3_31;
   assign w3_in[3][1] = w3_32;
   assign w3_in[3][2] = w3_33;
   assign w3_in[3][3] = w3_34;
   assign w3_in[4][0] = w3_41;
   assign w3_in[4][1] = w3_42;
   assign w3_in[4][2] = w3_43;
   assign w3_in[4][3] = w3_44;
   assign w3_in[5][0] = w3_51;
   assign w3_in[5][1] = w3_52;
   assign w3_in[5][2] = w3_53;
   assign w3_in[5][3] = w3_54;

   always_comb begin
      diff    = {a3_q[15], a3_q} - {tgt_q[15], tgt_q};
      e_calc  = sat33({{16{diff[16]}}, diff});
      db_calc = shr(neg16(e_calc), lr_q);

      // Keep the operand mux in range once the issue counter runs past 5.
      sel = idx_q;
      if (idx_q == 3'd0 || idx_q > 3'd5) begin
         sel = 3'd5;
      end
      iss_p    = 32'(e_q) * 32'(a2_q[sel]);
      iss_q    = 32'(e_q) * 32'(wc_q[sel]);
      iss_gate = a2_q[sel] > 16'sd0;

      // Q12.20 product back to Q6.10; the slice is in range iff bits [31:25] agree.
      pp_sh    = pp_q >>> 10;
      pq_sh    = pq_q >>> 10;
      dw_calc  = shr(sat33(-$signed({pp_sh[31], pp_sh})), lr_q);
      err_calc = pgate_q ? sat33($signed({pq_sh[31], pq_sh})) : 16'h0000;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (start) state_d = StErr;
         StErr:  state_d = StUpd;
         StUpd:  if (pvalid_q && pidx_q == 3'd5) state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_q    <= 2'd0;
         lr_q     <= 4'd0;
         tgt_q    <= 16'sd0;
         a3_q     <= 16'sd0;
         e_q      <= 16'sd0;
         idx_q    <= 3'd1;
         pp_q     <= 32'sd0;
         pq_q     <= 32'sd0;
         pidx_q   <= 3'd1;
         pgate_q  <= 1'b0;
         pvalid_q <= 1'b0;
         for (int i = 1; i <= 5; i++) begin
            a2_q[i]  <= 16'sd0;
            wc_q[i]  <= 16'sd0;
            err_q[i] <= 16'h0000;
            for (int j = 0; j < 4; j++) begin
               dw_q[i][j] <= 16'h0000;
            end
         end
         for (int j = 0; j < 4; j++) begin
            db_q[j] <= 16'h0000;
         end
      end else begin
         pvalid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  act_q <= act;
                  lr_q  <= lr_shift;
                  tgt_q <= target;
                  a3_q  <= a3_in[act];
                  idx_q <= 3'd1;
                  for (int i = 1; i <= 5; i++) begin
                     a2_q[i]  <= a2_in[i];
                     wc_q[i]  <= w3_in[i][act];
                     err_q[i] <= 16'h0000;
                     for (int j = 0; j < 4; j++) begin
                        dw_q[i][j] <= 16'h0000;
                     end
                  end
                  for (int j = 0; j < 4; j++) begin
                     db_q[j] <= 16'h0000;
                  end
               end
            end
            StErr: begin
               e_q         <= e_calc;
               db_q[act_q] <= db_calc;
            end
            StUpd: begin
               if (idx_q <= 3'd5) begin
                  pp_q     <= iss_p;
                  pq_q     <= iss_q;
                  pgate_q  <= iss_gate;
                  pidx_q   <= idx_q;
                  pvalid_q <= 1'b1;
                  idx_q    <= idx_q + 3'd1;
               end
               if (pvalid_q) begin
                  dw_q[pidx_q][act_q] <= dw_calc;
                  err_q[pidx_q]       <= err_calc;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);

   assign deltaw3_11 = dw_q[1][0];
   assign deltaw3_12 = dw_q[1][1];
   assign deltaw3_13 = dw_q[1][2];
   assign deltaw3_14 = dw_q[1][3];
   assign deltaw3_21 = dw_q[2][0];
   assign deltaw3_22 = dw_q[2][1];
   assign deltaw3_23 = dw_q[2][2];
   assign deltaw3_24 = dw_q[2][3];
   assign deltaw3_31 = dw_q[3][0];
   assign deltaw3_32 = dw_q[3][1];
   assign deltaw3_33 = dw_q[3][2];
   assign deltaw3_34 = dw_q[3][3];
   assign deltaw3_41 = dw_q[4][0];
   assign deltaw3_42 = dw_q[4][1];
   assign deltaw3_43 = dw_q[4][2];
   assign deltaw3_44 = dw_q[4][3];
   assign deltaw3_51 = dw_q[5][0];
   assign deltaw3_52 = dw_q[5][1];
   assign deltaw3_53 = dw_q[5][2];
   assign deltaw3_54 = dw_q[5][3];

   assign deltab3_1 = db_q[0];
   assign deltab3_2 = db_q[1];
   assign deltab3_3 = db_q[2];
   assign deltab3_4 = db_q[3];

   assign err2_1 = err_q[1];
   assign err2_2 = err_q[2];
   assign err2_3 = err_q[3];
   assign err2_4 = err_q[4];
   assign err2_5 = err_q[5];

endmodule

// File: tb/tb_bwd_prop_out.sv
module tb_bwd_prop_out;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start;
   logic [1:0]  act;
   logic [15:0] target;
   logic [3:0]  lr_shift;
   logic [15:0] a2 [1:5];
   logic [15:0] a3 [1:4];
   logic [15:0] w3 [1:5][1:4];
   logic [15:0] dw [1:5][1:4];
   logic [15:0] db [1:4];
   logic [15:0] er [1:5];
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bwd_prop_out dut (
      .clk(clk), .rst(rst), .start(start), .act(act), .target(target), .lr_shift(lr_shift),
      .a2_1(a2[1]), .a2_2(a2[2]), .a2_3(a2[3]), .a2_4(a2[4]), .a2_5(a2[5]),
      .a3_1(a3[1]), .a3_2(a3[2]), .a3_3(a3[3]), .a3_4(a3[4]),
      .w3_11(w3[1][1]), .w3_12(w3[1][2]), .w3_13(w3[1][3]), .w3_14(w3[1][4]),
      .w3_21(w3[2][1]), .w3_22(w3[2][2]), .w3_23(w3[2][3]), .w3_24(w3[2][4]),
      .w3_31(w3[3][1]), .w3_32(w3[3][2]), .w3_33(w3[3][3]), .w3_34(w3[3][4]),
      .w3_41(w3[4][1]), .w3_42(w3[4][2]), .w3_43(w3[4][3]), .w3_44(w3[4][4]),
      .w3_51(w3[5][1]), .w3_52(w3[5][2]), .w3_53(w3[5][3]), .w3_54(w3[5][4]),
      .deltaw3_11(dw[1][1]), .deltaw3_12(dw[1][2]), .deltaw3_13(dw[1][3]), .deltaw3_14(dw[1][4]),
      .deltaw3_21(dw[2][1]), .deltaw3_22(dw[2][2]), .deltaw3_23(dw[2][3]), .deltaw3_24(dw[2][4]),
      .deltaw3_31(dw[3][1]), .deltaw3_32(dw[3][2]), .deltaw3_33(dw[3][3]), .deltaw3_34(dw[3][4]),
      .deltaw3_41(dw[4][1]), .deltaw3_42(dw[4][2]), .deltaw3_43(dw[4][3]), .deltaw3_44(dw[4][4]),
      .deltaw3_51(dw[5][1]), .deltaw3_52(dw[5][2]), .deltaw3_53(dw[5][3]), .deltaw3_54(dw[5][4]),
      .deltab3_1(db[1]), .deltab3_2(db[2]), .deltab3_3(db[3]), .deltab3_4(db[4]),
      .err2_1(er[1]), .err2_2(er[2]), .err2_3(er[3]), .err2_4(er[4]), .err2_5(er[5]),
      .busy(busy), .done(done)
   );

   // ---------------- behavioural model ----------------
   // cnt = cycles since the accepting edge (0 = idle); done is due when cnt == 8.
   int cnt = 0;
   bit m_valid = 1'b0;
   int m_act, m_lr, m_tgt, m_a3;
   int m_a2 [1:5];
   int m_w  [1:5];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 0;
         m_valid <= 1'b0;
      end else if (cnt == 0) begin
         if (start) begin
            cnt     <= 1;
            m_valid <= 1'b1;
            m_act   <= int'(act);
            m_lr    <= int'(lr_shift);
            m_tgt   <= int'($signed(target));
            m_a3    <= int'($signed(a3[int'(act) + 1]));
            for (int i = 1; i <= 5; i++) begin
               m_a2[i] <= int'($signed(a2[i]));
               m_w[i]  <= int'($signed(w3[i][int'(act) + 1]));
            end
         end
      end else if (cnt == 8) begin
         cnt <= 0;
      end else begin
         cnt <= cnt + 1;
      end
   end

   function automatic int sat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic int exp_e();
      return sat(longint'(m_a3) - longint'(m_tgt));
   endfunction

   function automatic int exp_db(input int j);
      int r;
      if (!m_valid || j != m_act + 1) return 0;
      r = sat(-longint'(exp_e()));
      return r >>> m_lr;
   endfunction

   function automatic int exp_dw(input int i, input int j);
      longint p;
      int r;
      if (!m_valid || j != m_act + 1) return 0;
      p = longint'(exp_e()) * longint'(m_a2[i]);
      r = sat(-(p >>> 10));
      return r >>> m_lr;
   endfunction

   function automatic int exp_err(input int i);
      longint q;
      if (!m_valid || m_a2[i] <= 0) return 0;
      q = longint'(exp_e()) * longint'(m_w[i]);
      return sat(q >>> 10);
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Every cycle: control outputs; data outputs whenever they must be final.
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", {15'd0, busy}, {15'd0, cnt != 0});
         chk("done", {15'd0, done}, {15'd0, cnt == 8});
         if (cnt == 0 || cnt == 8) begin
            for (int j = 1; j <= 4; j++) begin
               chk($sformatf("deltab3_%0d", j), db[j], 16'(exp_db(j)));
            end
            for (int i = 1; i <= 5; i++) begin
               chk($sformatf("err2_%0d", i), er[i], 16'(exp_err(i)));
               for (int j = 1; j <= 4; j++) begin
                  chk($sformatf("deltaw3_%0d%0d", i, j), dw[i][j], 16'(exp_dw(i, j)));
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_in();
      start    = 1'b0;
      act      = 2'd0;
      target   = 16'h0000;
      lr_shift = 4'd0;
      for (int i = 1; i <= 5; i++) begin
         a2[i] = 16'h0000;
         for (int j = 1; j <= 4; j++) w3[i][j] = 16'h0000;
      end
      for (int j = 1; j <= 4; j++) a3[j] = 16'h0000;
   endtask

   task automatic base_vec();
      clear_in();
      act      = 2'd0;
      a3[1]    = 16'h0800;
      target   = 16'h0400;
      lr_shift = 4'd2;
      a2[1]    = 16'h0400;
      for (int i = 2; i <= 5; i++) a2[i] = 16'h0200;
      w3[1][1] = 16'h0400;
   endtask

   // Pulse start, then wait (bounded) for done; edges = edge count incl. the sampling edge.
   task automatic run_pass(output int edges);
      @(negedge clk);
      start = 1'b1;
      edges = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            edges = k;
            break;
         end
      end
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (done) n++;
      end
   endtask

   initial begin
      int edges;
      int nd;
      clear_in();
      #12 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_db1", db[1], 16'h0000);
      chk("rst_dw11", dw[1][1], 16'h0000);

      // Basic pass
      base_vec();
      run_pass(edges);
      chk("basic_latency", 16'(edges), 16'd8);
      chk("basic_db1", db[1], 16'hFF00);
      chk("basic_dw11", dw[1][1], 16'hFF00);
      chk("basic_dw21", dw[2][1], 16'hFF80);
      chk("basic_err1", er[1], 16'h0400);
      chk("basic_db2", db[2], 16'h0000);
      chk("basic_dw12", dw[1][2], 16'h0000);
      repeat (2) @(negedge clk);

      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      chk("arst_dw11", dw[1][1], 16'h0000);
      chk("arst_db1", db[1], 16'h0000);
      chk("arst_err1", er[1], 16'h0000);
      chk("arst_busy", {15'd0, busy}, 16'd0);
      chk("arst_done", {15'd0, done}, 16'd0);
      #1 rst = 1'b0;

      // ReLU gate
      base_vec();
      a2[3]    = 16'hFC00;
      w3[3][1] = 16'h0400;
      run_pass(edges);
      chk("relu_err3", er[3], 16'h0000);
      chk("relu_dw31", dw[3][1], 16'h0100);

      // Saturation
      clear_in();
      act      = 2'd1;
      a3[2]    = 16'h7FFF;
      target   = 16'h8000;
      lr_shift = 4'd0;
      a2[1]    = 16'h7FFF;
      run_pass(edges);
      chk("sat_db2", db[2], 16'h8001);
      chk("sat_dw12", dw[1][2], 16'h8000);

      // Negative saturation, -0x8000 negation and product-slice clamp
      clear_in();
      act      = 2'd2;
      a3[3]    = 16'h8000;
      target   = 16'h7FFF;
      a2[1]    = 16'h8000;
      a2[2]    = 16'h0001;
      a2[3]    = 16'h0400;
      w3[2][3] = 16'h0400;
      w3[3][3] = 16'h8000;
      run_pass(edges);
      chk("neg_db3", db[3], 16'h7FFF);
      chk("neg_dw13", dw[1][3], 16'h8000);
      chk("neg_dw23", dw[2][3], 16'h0020);
      chk("neg_err1", er[1], 16'h0000);
      chk("neg_err2", er[2], 16'h8000);
      chk("neg_err3", er[3], 16'h7FFF);

      // Mixed-sign vector, model only
      clear_in();
      act      = 2'd3;
      a3[4]    = 16'hF000;
      target   = 16'h0C00;
      lr_shift = 4'd1;
      a2[1] = 16'h0123; a2[2] = 16'hFF00; a2[3] = 16'h0A00; a2[4] = 16'h0000; a2[5] = 16'h3000;
      w3[1][4] = 16'h0200; w3[2][4] = 16'h0300; w3[3][4] = 16'hF800;
      w3[4][4] = 16'h0100; w3[5][4] = 16'h1000;
      w3[1][1] = 16'h7777;
      run_pass(edges);
      chk("mix_latency", 16'(edges), 16'd8);

      // Start while busy is ignored; input changes mid-pass have no effect
      base_vec();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      act   = 2'd2;
      a2[1] = 16'h7000;
      a3[3] = 16'h1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      count_done(15, nd);
      chk("busy_done_count", 16'(nd), 16'd1);
      chk("busy_db1", db[1], 16'hFF00);
      chk("busy_db3", db[3], 16'h0000);
      chk("busy_dw11", dw[1][1], 16'hFF00);
      chk("busy_err1", er[1], 16'h0400);

      // Abort during UPD, then restart
      base_vec();
      a2[3]    = 16'hFC00;
      w3[3][1] = 16'h0400;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_dw11", dw[1][1], 16'h0000);
      chk("abort_db1", db[1], 16'h0000);
      chk("abort_err1", er[1], 16'h0000);
      chk("abort_busy", {15'd0, busy}, 16'd0);
      #1 rst = 1'b0;
      count_done(12, nd);
      chk("abort_no_done", 16'(nd), 16'd0);
      run_pass(edges);
      chk("restart_latency", 16'(edges), 16'd8);
      chk("restart_db1", db[1], 16'hFF00);
      chk("restart_dw31", dw[3][1], 16'h0100);
      chk("restart_err3", er[3], 16'h0000);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/bwd_prop_out.md
BWD_PROP_OUT -- requirements
Module: bwd_prop_out

Interface
REQ-001 SHALL have one clock and asynchronous active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 SHALL have the following ports, all data signed Q6.10 (16 bit, 10 fractional bits):
- start  in  1  pulse; request one backward pass
- act  in  2  chosen action index 0..3 (output neuron act+1)
- target  in  16  TD target Q value
- lr_shift  in  4  learning rate, expressed as arithmetic right shift
- a2_1..a2_5  in  16 each  hidden activations
- a3_1..a3_4  in  16 each  output activations
- w3_11..w3_54  in  16 each  current output weights, hidden i to output j
- deltaw3_11..deltaw3_54  out  16 each  weight updates
- deltab3_1..deltab3_4  out  16 each  bias updates
- err2_1..err2_5  out  16 each  back-propagated hidden error
- busy  out  1  pass in progress
- done  out  1  one-cycle completion pulse

Function
REQ-003 SHALL implement FSM states IDLE, ERR, UPD and DONE; busy = (state != IDLE).
REQ-004 IDLE with start=1 at a rising edge SHALL:
- capture act, target, lr_shift, a2_1..5, a3_(act+1) and column w3_1(act+1)..w3_5(act+1);
- clear all deltaw3, deltab3 and err2 outputs to 0;
- go to ERR.
REQ-005 ERR SHALL compute e = sat16(a3_(act+1) - target), register e and deltab3_(act+1) = sat16(-e) >>> lr_shift, then go to UPD with index i=1.
REQ-006 UPD SHALL process one hidden index i per cycle, for i = 1..5:
- p = e*a2_i (32 bit); deltaw3_i(act+1) = sat16(-(p[25:10])) >>> lr_shift;
- q = e*w3_i(act+1); err2_i = (a2_i > 0) ? q[25:10] saturated : 0.
REQ-007 UPD SHALL go to DONE after i=5.
REQ-008 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-009 Latency: start sampled at edge N -> done high in the cycle following edge N+7, and all outputs are final from that edge.
REQ-010 Columns j != act+1 of deltaw3, and deltab3_j for j != act+1, SHALL remain 0 (DQN: only the chosen action carries error).
REQ-011 sat16 of a wide value SHALL clamp to 0x7FFF / 0x8000 when the value is out of signed 16-bit range; a product slice SHALL saturate if bits [31:25] are not all equal.
REQ-012 Negation of 0x8000 SHALL yield 0x7FFF.
REQ-013 The right shift SHALL be arithmetic, applied after saturation; lr_shift=0 means no scaling.
REQ-014 start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-015 start in DONE SHALL be ignored; start is accepted only in IDLE.
REQ-016 Inputs other than those captured SHALL be don't-care after the capture edge; changes SHALL NOT affect the pass in progress.
REQ-017 Outputs SHALL hold their values in IDLE until the next accepted start or reset.

Reset
REQ-018 rst=1 SHALL asynchronously force state IDLE, busy=0, done=0, e=0, index=1, and all deltaw3, deltab3 and err2 outputs to 0x0000.
REQ-019 rst asserted mid-pass SHALL abort the pass; no done pulse is produced for the aborted pass.
REQ-020 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-021 Reset: pulse rst between clock edges -> every output 0 immediately, busy=0, done=0.
REQ-022 Basic pass:
- stimulus: act=0, a3_1=0x0800, target=0x0400, lr_shift=2, a2_1=0x0400, a2_2..5=0x0200, w3_11=0x0400;
- response: deltab3_1=0xFF00, deltaw3_11=0xFF00, deltaw3_21=0xFF80, err2_1=0x0400;
- all other deltaw3 and deltab3 = 0; done exactly 8 edges after start.
REQ-023 ReLU gate:
- stimulus: as REQ-022 but a2_3=0xFC00, w3_31=0x0400;
- response: err2_3=0x0000 and deltaw3_31=0x0100.
REQ-024 Saturation:
- stimulus: a3_2=0x7FFF, target=0x8000, act=1, lr_shift=0, a2_1=0x7FFF;
- response: e=0x7FFF, deltab3_2=0x8001, deltaw3_12=0x8000.
REQ-025 Busy rule: second start during UPD with different act -> ignored; outputs match the first request, single done pulse.
REQ-026 Abort: rst asserted during UPD i=3 -> all outputs 0, no done pulse; the following start completes correctly.
